lisnoc_vc_credit_scheduler: RTL

//  Credit-based link scheduler for one router output port. It shares the physical link among
//  the per-VC output FIFOs of that port: each cycle it picks one VC round-robin, pops its FIFO
//  and registers the flit onto the link. Per-VC credit counters track free downstream buffer

---
 rtl/lisnoc_vc_credit_scheduler.sv | 97 +++++++++
 1 files changed

// File: rtl/lisnoc_vc_credit_scheduler.sv
// Credit-based round-robin link scheduler for one router output port.
// Each cycle one VC with a flit and a free downstream slot is popped and its flit registered onto the link.
module lisnoc_vc_credit_scheduler #(
  parameter int flit_data_width = 32,
  parameter int flit_type_width = 2,
  parameter int vchannels       = 2,
  parameter int credit_max      = 4
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic [vchannels-1:0]                                  fifo_valid_i,
  input  logic [(flit_data_width+flit_type_width)*vchannels-1:0] fifo_flit_i,
  output logic [vchannels-1:0]                                  fifo_ready_o,
  output logic [flit_data_width+flit_type_width-1:0]            link_flit_o,
  output logic [vchannels-1:0]                                  link_valid_o,
  input  logic [vchannels-1:0]                                  link_credit_i,
  output logic [vchannels-1:0]                                  credit_err_o
);

  localparam int fw = flit_data_width + flit_type_width;
  localparam int cw = $clog2(credit_max + 1);
  localparam int pw = (vchannels > 1) ? $clog2(vchannels) : 1;

  logic [pw-1:0]        ptr_reg;
  logic [vchannels-1:0] elig;
  logic [vchannels-1:0] above;
  logic [vchannels-1:0] elig_hi;
  logic [vchannels-1:0] sel;
  logic [vchannels-1:0] grant;
  logic [vchannels-1:0] link_valid_reg;
  logic [fw-1:0]        link_flit_reg;
  logic [fw-1:0]        grant_flit;
  logic [pw-1:0]        grant_idx;

  genvar gi;
  generate
    for (gi = 0; gi < vchannels; gi++) begin : g_vc
      logic [cw-1:0] credit_reg;
      logic          err_reg;

      assign elig[gi]         = fifo_valid_i[gi] & (credit_reg != '0);
      assign above[gi]        = (ptr_reg < pw'(gi));
      assign credit_err_o[gi] = err_reg;

      // A grant and a returned credit in the same cycle cancel out.
      always_ff @(posedge clk) begin
        if (rst) begin
          credit_reg <= cw'(credit_max);
          err_reg    <= 1'b0;
        end else if (grant[gi] && !link_credit_i[gi]) begin
          credit_reg <= credit_reg - cw'(1);
        end else if (!grant[gi] && link_credit_i[gi]) begin
          if (credit_reg == cw'(credit_max)) begin
            err_reg <= 1'b1;
          end else begin
            credit_reg <= credit_reg + cw'(1);
          end
        end
      end
    end
  endgenerate

  // Prefer eligible VCs above the last winner; otherwise wrap to the lowest eligible one.
  assign elig_hi = elig & above;
  assign sel     = (elig_hi != '0) ? elig_hi : elig;
  assign grant   = rst ? '0 : (sel & (-sel));

  always_comb begin
    grant_flit = '0;
    grant_idx  = '0;
    for (int v = 0; v < vchannels; v++) begin
      if (grant[v]) begin
        grant_flit = fifo_flit_i[v*fw +: fw];
        grant_idx  = pw'(v);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg        <= pw'(vchannels - 1);
      link_valid_reg <= '0;
      link_flit_reg  <= '0;
    end else begin
      link_valid_reg <= grant;
      if (grant != '0) begin
        ptr_reg       <= grant_idx;
        link_flit_reg <= grant_flit;
      end
    end
  end

  assign fifo_ready_o = grant;
  assign link_valid_o = link_valid_reg;
  assign link_flit_o  = link_flit_reg;

endmodule
